// File: rtl/seq_dual_lane_fifo.sv
// Two-lane byte collector feeding a shared first-word-fall-through FIFO.
// Round-robin grant when both lanes offer in the same cycle; each entry carries its lane tag.
module seq_dual_lane_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_valid,
  input  logic [WIDTH-1:0] q_data,
  output logic             q_ready,
  input  logic             r_valid,
  input  logic [WIDTH-1:0] r_data,
  output logic             r_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_lane,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_tag;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_prio;

  logic             w_full;
  logic             w_empty;
  logic             w_push_q;
  logic             w_push_r;
  logic             w_push;
  logic             w_pop;
  logic             w_push_lane;
  logic [WIDTH-1:0] w_push_data;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Full blocks both lanes even when a pop lands in the same cycle.
  always_comb begin
    q_ready = 1'b0;
    r_ready = 1'b0;
    if (!w_full) begin
      if (q_valid && r_valid) begin
        q_ready = ~r_prio;
        r_ready = r_prio;
      end else begin
        q_ready = 1'b1;
        r_ready = 1'b1;
      end
    end
  end

  assign w_push_q    = q_valid && q_ready;
  assign w_push_r    = r_valid && r_ready;
  assign w_push      = w_push_q || w_push_r;
  assign w_push_lane = w_push_r;
  assign w_push_data = w_push_r ? r_data : q_data;
  assign w_pop       = !w_empty && out_ready;

  assign out_valid = !w_empty;
  assign out_data  = r_mem[r_rd_ptr];
  assign out_lane  = r_tag[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_tag <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
      r_tag[r_wr_ptr] <= w_push_lane;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_prio   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_prio   <= ~w_push_lane;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_dual_lane_fifo.sv
// Directed bench for seq_dual_lane_fifo with a queue scoreboard and a small occupancy/priority model.
module tb_seq_dual_lane_fifo;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } ent_t;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic       q_valid;
  logic [7:0] q_data;
  logic       q_ready;
  logic       r_valid;
  logic [7:0] r_data;
  logic       r_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_lane;
  logic       out_ready;
  logic [2:0] count;

  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];
  int   m_count = 0;
  logic m_prio  = 1'b0;

  seq_dual_lane_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .q_valid(q_valid), .q_data(q_data), .q_ready(q_ready),
    .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready),
    .out_valid(out_valid), .out_data(out_data), .out_lane(out_lane),
    .out_ready(out_ready), .count(count)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check settled outputs against the model, advance past posedge.
  task automatic step(input logic qv, input logic [7:0] qd, input logic rv,
                      input logic [7:0] rd, input logic ordy);
    logic full, eq, er;
    ent_t e;
    q_valid = qv; q_data = qd; r_valid = rv; r_data = rd; out_ready = ordy;
    #1;
    full = (m_count == 4);
    eq = !full && ((qv && rv) ? !m_prio : 1'b1);
    er = !full && ((qv && rv) ?  m_prio : 1'b1);
    chk("q_ready", {31'd0, q_ready}, {31'd0, eq});
    chk("r_ready", {31'd0, r_ready}, {31'd0, er});
    chk("count", {29'd0, count}, m_count);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_count != 0});
    if (m_count != 0) begin
      chk("head_data", {24'd0, out_data}, {24'd0, sb[0].d});
      chk("head_lane", {31'd0, out_lane}, {31'd0, sb[0].l});
    end
    if (ordy && m_count != 0) begin
      void'(sb.pop_front());
      m_count--;
    end
    if ((qv && eq) || (rv && er)) begin
      e.l = rv && er;
      e.d = e.l ? rd : qd;
      sb.push_back(e);
      m_count++;
      m_prio = ~e.l;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    sb.delete();
    m_count = 0;
    m_prio  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clk_en = 1'b0;
    rst_n = 1'b1; q_valid = 1'b1; q_data = 8'h00; r_valid = 1'b0; r_data = 8'h00; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_count", {29'd0, count}, 32'd0);
    chk("async_out_data", {24'd0, out_data}, 32'd0);
    chk("async_out_lane", {31'd0, out_lane}, 32'd0);
    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_q_ready", {31'd0, q_ready}, 32'd1);

    // Single lane
    step(1, 8'hA1, 0, 8'h00, 0);
    step(1, 8'hA2, 0, 8'h00, 0);
    step(1, 8'hA3, 0, 8'h00, 0);
    chk("single_count3", {29'd0, count}, 32'd3);
    chk("single_head", {24'd0, out_data}, 32'hA1);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 8'h00, 1);
    chk("single_empty", {31'd0, out_valid}, 32'd0);
    step(0, 8'h00, 0, 8'h00, 1);
    chk("empty_pop_ignored", {29'd0, count}, 32'd0);

    // Arbitration from prio = 0
    do_reset();
    #1;
    chk("arb_first_q", {31'd0, q_ready}, 32'd1);
    for (int n = 0; n < 4; n++) step(1, 8'h10 + n[7:0], 1, 8'h20 + n[7:0], 0);
    chk("arb_head_10", {24'd0, out_data}, 32'h10);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 8'h00, 1);

    // Full: no pass-through while a pop is in flight
    for (int i = 0; i < 4; i++) step(1, 8'h40 + i[7:0], 0, 8'h00, 0);
    #1;
    chk("full_count", {29'd0, count}, 32'd4);
    step(1, 8'h4F, 0, 8'h00, 1);
    chk("full_after_pop", {29'd0, count}, 32'd3);
    step(1, 8'h50, 0, 8'h00, 0);
    chk("full_refill", {29'd0, count}, 32'd4);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 8'h00, 1);

    // Wrap-around at steady occupancy 2
    step(1, 8'h60, 0, 8'h00, 0);
    step(0, 8'h00, 1, 8'h61, 0);
    for (int i = 0; i < 10; i++) step(i[0] == 1'b0, 8'h70 + i[7:0], i[0] == 1'b1, 8'h80 + i[7:0], 1);
    chk("wrap_count", {29'd0, count}, 32'd2);
    for (int i = 0; i < 2; i++) step(0, 8'h00, 0, 8'h00, 1);

    // Async reset mid-operation
    for (int i = 0; i < 3; i++) step(1, 8'h90 + i[7:0], 0, 8'h00, 0);
    out_ready = 1'b1;
    do_reset();
    step(1, 8'h5C, 0, 8'h00, 0);
    chk("post_reset_count", {29'd0, count}, 32'd1);
    chk("post_reset_head", {24'd0, out_data}, 32'h5C);
    step(0, 8'h00, 0, 8'h00, 1);
    step(0, 8'h00, 0, 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
